// File: rtl/tinyalu_pkg.sv
// Shared tinyalu definitions: widths, the ALU operation encoding, the
// buffered command record and the command-driver FSM state type.
// No ports; imported by the driver and its command FIFO.
package tinyalu_pkg;

  localparam int OP_W     = 3;
  localparam int DATA_W   = 8;
  localparam int RESULT_W = 16;

  // Encodings 101 and 110 are unused by the ALU and are treated like no_op.
  typedef enum logic [OP_W-1:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef struct packed {
    operation_t        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RST,
    RESP
  } drv_state_t;

  // Operations that produce a result and therefore a response.
  function automatic logic is_arith(operation_t op);
    case (op)
      ADD_OP, AND_OP, XOR_OP, MUL_OP: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous command FIFO for the tinyalu driver. Head entry is visible
// combinationally; a pushed entry becomes visible on the following cycle.
// Ports:
//   clk, reset             clock, asynchronous active-high reset (empties FIFO)
//   push, push_data        write request (ignored when full) and entry
//   pop                    remove head (ignored when empty)
//   head                   current head entry
//   full, empty, count     occupancy status
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so the power-of-two depth makes
  // them wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty/count guard against reading stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Command driver for the tinyalu. Buffers valid/ready commands in a FIFO,
// drives the ALU start/op/A/B/reset_n pins with the start-hold protocol,
// aborts a command whose done never arrives, and returns results over a
// valid/ready response interface.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_op/a/b     command input
//   alu_start/op/a/b, alu_reset_n   pins to the tinyalu
//   alu_done, alu_result            pins from the tinyalu
//   rsp_valid/ready                 response handshake
//   rsp_result/op/timeout           response payload
//   busy                            work pending or in progress
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                alu_start,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_reset_n,
  input  logic                alu_done,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESULT_W-1:0] rsp_result,
  output logic [OP_W-1:0]     rsp_op,
  output logic                rsp_timeout,
  output logic                busy
);

  localparam int TW = $clog2(DONE_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  cmd_t                        fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        pop;

  drv_state_t          state_q, state_d;
  logic                alu_start_q, alu_start_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                alu_reset_n_q, alu_reset_n_d;
  logic [RESULT_W-1:0] rsp_result_q, rsp_result_d;
  logic [OP_W-1:0]     rsp_op_q, rsp_op_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;

  tinyalu_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data ('{op: operation_t'(cmd_op), a: cmd_a, b: cmd_b}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready   = !fifo_full && !reset;
  assign alu_start   = alu_start_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  // The pulse register idles high; masking with reset lets the ALU leave
  // reset in the very first cycle after release.
  assign alu_reset_n = alu_reset_n_q && !reset;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);

  // Next-state and next-output logic. Every ALU pin and response field is
  // registered, so values chosen here appear on the pins one cycle later.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    alu_start_d   = 1'b0;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_reset_n_d = 1'b1;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        // A no_op start pulse is being driven this cycle; popping now would
        // merge the pulse with the next command's start.
        if (!fifo_empty && !alu_start_q) begin
          pop       = 1'b1;
          alu_op_d  = fifo_head.op;
          alu_a_d   = fifo_head.a;
          alu_b_d   = fifo_head.b;
          tmo_cnt_d = '0;
          if (is_arith(fifo_head.op)) begin
            alu_start_d = 1'b1;
            state_d     = EXEC;
          end else if (fifo_head.op == RST_OP) begin
            alu_reset_n_d = 1'b0;
            state_d       = RST;
          end else begin
            alu_start_d = 1'b1;
          end
        end
      end

      EXEC: begin
        // Done wins over the timeout when both land in the same cycle.
        if (alu_done) begin
          rsp_result_d  = alu_result;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_result_d  = '0;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          alu_start_d = 1'b1;
          tmo_cnt_d   = tmo_cnt_q + TW'(1);
        end
      end

      RST: begin
        state_d = IDLE;
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      alu_start_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_reset_n_q <= 1'b1;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      alu_start_q   <= alu_start_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_reset_n_q <= alu_reset_n_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Bench for tinyalu_cmd_driver: behavioural tinyalu model plus a response
// scoreboard fed at command acceptance.
module tb_tinyalu_cmd_driver;

  localparam int FIFO_DEPTH   = 4;
  localparam int DONE_TIMEOUT = 16;
  localparam int MUL_LAT      = 3;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] result;
    logic        timeout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_reset_n;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  int   startCycles = 0;
  int   resetLowCycles = 0;
  int   rspCount = 0;
  logic [15:0] lastRspResult = '0;
  logic        lastRspTimeout = 1'b0;
  logic        neverDone = 1'b0;
  int          latCnt = 0;

  tinyalu_cmd_driver #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_reset_n(alu_reset_n),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int latFor(input logic [2:0] op);
    return (op == 3'b100) ? MUL_LAT : 1;
  endfunction

  function automatic logic [15:0] refResult(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'hDEAD;
    endcase
  endfunction

  // Behavioural tinyalu: done is a one-cycle pulse after start has been seen
  // for the op's latency. No_op also pulses done, which the driver must ignore.
  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (!alu_reset_n) begin
      latCnt <= 0;
    end else if (alu_start && !alu_done && !neverDone) begin
      if (latCnt == latFor(alu_op) - 1) begin
        alu_done   <= 1'b1;
        alu_result <= refResult(alu_op, alu_a, alu_b);
        latCnt     <= 0;
      end else begin
        latCnt <= latCnt + 1;
      end
    end else begin
      latCnt <= 0;
    end
  end

  // Response monitor and pin activity counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_start) startCycles++;
      if (!alu_reset_n) resetLowCycles++;
      if (rsp_valid) checkOutput("rsp_start_low", {31'b0, alu_start}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        rspCount++;
        lastRspResult  = rsp_result;
        lastRspTimeout = rsp_timeout;
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("rsp_result", {16'b0, rsp_result}, {16'b0, e.result});
          checkOutput("rsp_op", {29'b0, rsp_op}, {29'b0, e.op});
          checkOutput("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.timeout});
        end
      end
    end
  end

  // Drives one command until accepted; called just after a rising edge and
  // returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int waitCycles;
    exp_t e;
    waitCycles = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    while (!cmd_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_accept", {31'b0, cmd_ready}, 32'd1);
    end else if (op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      e.op      = op;
      e.timeout = neverDone;
      e.result  = neverDone ? 16'h0000 : refResult(op, a, b);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || alu_start || rsp_valid || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("drain", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, l0, r0, n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("rst_alu_reset_n", {31'b0, alu_reset_n}, 32'd0);
    checkOutput("rst_alu_start", {31'b0, alu_start}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_rsp_result", {16'b0, rsp_result}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("rel_alu_reset_n", {31'b0, alu_reset_n}, 32'd1);
    @(posedge clk);
    #1;

    // 1: add FF+01, response valid 4 cycles after acceptance
    $display("[TB] add latency");
    applyStimulus(3'b001, 8'hFF, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t1_rsp_valid_lat", {31'b0, rsp_valid}, {31'b0, (k == 4)});
      if (k == 4) begin
        checkOutput("t1_result", {16'b0, rsp_result}, 32'h0100);
        checkOutput("t1_op", {29'b0, rsp_op}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    waitIdle();

    // 2: mul FF*FF, start held until done
    $display("[TB] mul start hold");
    s0 = startCycles;
    r0 = rspCount;
    applyStimulus(3'b100, 8'hFF, 8'hFF);
    waitIdle();
    checkOutput("t2_start_cycles", startCycles - s0, MUL_LAT + 1);
    checkOutput("t2_rsp_count", rspCount - r0, 1);
    checkOutput("t2_result", {16'b0, lastRspResult}, 32'hFE01);

    // 3: fill FIFO while responses are stalled, then drain in order
    $display("[TB] fifo full and ordering");
    r0 = rspCount;
    rsp_ready = 1'b0;
    applyStimulus(3'b001, 8'h12, 8'h34);
    applyStimulus(3'b010, 8'hF0, 8'h3C);
    applyStimulus(3'b011, 8'h5A, 8'h0F);
    applyStimulus(3'b100, 8'h10, 8'h20);
    applyStimulus(3'b001, 8'hFF, 8'hFF);
    @(negedge clk);
    checkOutput("t3_full_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("t3_busy", {31'b0, busy}, 32'd1);
    fork
      applyStimulus(3'b100, 8'h03, 8'h07);
      begin
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    waitIdle();
    checkOutput("t3_rsp_count", rspCount - r0, 6);

    // 4: no_op, illegal op, rst_op, xor
    $display("[TB] no_op / rst_op / xor");
    s0 = startCycles;
    l0 = resetLowCycles;
    r0 = rspCount;
    applyStimulus(3'b000, 8'h00, 8'h00);
    applyStimulus(3'b110, 8'h11, 8'h22);
    applyStimulus(3'b111, 8'h00, 8'h00);
    applyStimulus(3'b011, 8'hAA, 8'hFF);
    waitIdle();
    checkOutput("t4_start_cycles", startCycles - s0, 4);
    checkOutput("t4_reset_low", resetLowCycles - l0, 1);
    checkOutput("t4_rsp_count", rspCount - r0, 1);
    checkOutput("t4_result", {16'b0, lastRspResult}, 32'h0055);

    // 5: ALU never answers -> timeout response
    $display("[TB] done timeout");
    neverDone = 1'b1;
    s0 = startCycles;
    r0 = rspCount;
    applyStimulus(3'b010, 8'h0F, 8'hF0);
    waitIdle();
    neverDone = 1'b0;
    checkOutput("t5_start_cycles", startCycles - s0, DONE_TIMEOUT);
    checkOutput("t5_rsp_count", rspCount - r0, 1);
    checkOutput("t5_timeout", {31'b0, lastRspTimeout}, 32'd1);
    checkOutput("t5_result", {16'b0, lastRspResult}, 32'd0);

    // 6: reset during a mul in flight with another command queued
    $display("[TB] reset mid-exec");
    r0 = rspCount;
    applyStimulus(3'b100, 8'h07, 8'h09);
    applyStimulus(3'b001, 8'h01, 8'h02);
    n = 0;
    @(negedge clk);
    while (!alu_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_exec_reached", {31'b0, alu_start}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t6_alu_start", {31'b0, alu_start}, 32'd0);
    checkOutput("t6_alu_reset_n", {31'b0, alu_reset_n}, 32'd0);
    checkOutput("t6_alu_op", {29'b0, alu_op}, 32'd0);
    checkOutput("t6_alu_a", {24'b0, alu_a}, 32'd0);
    checkOutput("t6_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("t6_busy", {31'b0, busy}, 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("t6_no_rsp", rspCount - r0, 0);
    checkOutput("t6_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("t6_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Recovery after reset
    applyStimulus(3'b001, 8'h12, 8'h34);
    waitIdle();
    checkOutput("t6_recover_result", {16'b0, lastRspResult}, 32'h0046);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
